// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared tag width, ALU opcodes and entry types for the reservation station
package reservation_station_pkg;

    localparam int ROB_WIDTH = 4;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    typedef struct packed {
        logic                 pend;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          val;
    } operand_t;

    typedef struct packed {
        logic                 busy;
        logic [3:0]           op;
        logic [ROB_WIDTH-1:0] rob_id;
        operand_t             j;
        operand_t             k;
    } rs_entry_t;

    // Resolve a pending operand against the two result buses; the load bus wins on a tie.
    function automatic operand_t wake_operand(
        input operand_t             o,
        input logic                 a_vld,
        input logic [ROB_WIDTH-1:0] a_tag,
        input logic [31:0]          a_data,
        input logic                 b_vld,
        input logic [ROB_WIDTH-1:0] b_tag,
        input logic [31:0]          b_data
    );
        operand_t r;
        r = o;
        if (o.pend && a_vld && (o.tag == a_tag)) begin
            r.pend = 1'b0;
            r.val  = a_data;
        end else if (o.pend && b_vld && (o.tag == b_tag)) begin
            r.pend = 1'b0;
            r.val  = b_data;
        end
        return r;
    endfunction

endpackage

// File: rtl/reservation_station_alu.sv
// rtl/reservation_station_alu.sv - combinational integer ALU used by the reservation station
module alu
    import reservation_station_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'd0, a < b};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - operand-wakeup reservation station with a registered single-result ALU port
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE  = 8,
    parameter int RS_WIDTH = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 iss_en,
    input  logic [3:0]           iss_op,
    input  logic [ROB_WIDTH-1:0] iss_rob_id,
    input  logic [31:0]          iss_vj,
    input  logic [31:0]          iss_vk,
    input  logic                 iss_qj_busy,
    input  logic                 iss_qk_busy,
    input  logic [ROB_WIDTH-1:0] iss_qj,
    input  logic [ROB_WIDTH-1:0] iss_qk,
    output logic                 full,
    input  logic                 lsb_rdy,
    input  logic [ROB_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]          lsb_data,
    output logic                 rs_rdy,
    output logic [ROB_WIDTH-1:0] rs_rob_id,
    output logic [31:0]          rs_data,
    input  logic                 rs_en,
    input  logic                 flush
);

    rs_entry_t           ent [RS_SIZE];
    logic [RS_SIZE-1:0]  busy_vec;
    logic [RS_SIZE-1:0]  ready_vec;
    logic                sel_found;
    logic [RS_WIDTH-1:0] sel_idx;
    logic [RS_WIDTH-1:0] free_idx;
    logic                sel_go;
    logic                rs_bcast;
    logic [31:0]         alu_result;
    operand_t            iss_j;
    operand_t            iss_k;

    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = ent[i].busy;
            ready_vec[i] = ent[i].busy && !ent[i].j.pend && !ent[i].k.pend;
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        free_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                sel_found = 1'b1;
                sel_idx   = RS_WIDTH'(i);
            end
            if (!busy_vec[i]) begin
                free_idx = RS_WIDTH'(i);
            end
        end
    end

    assign full     = &busy_vec;
    assign rs_bcast = rs_rdy && rs_en;
    assign sel_go   = sel_found && (!rs_rdy || rs_en);

    assign iss_j = wake_operand('{pend: iss_qj_busy, tag: iss_qj, val: iss_vj},
                                lsb_rdy, lsb_rob_id, lsb_data, rs_bcast, rs_rob_id, rs_data);
    assign iss_k = wake_operand('{pend: iss_qk_busy, tag: iss_qk, val: iss_vk},
                                lsb_rdy, lsb_rob_id, lsb_data, rs_bcast, rs_rob_id, rs_data);

    alu u_alu (
        .op     (ent[sel_idx].op),
        .a      (ent[sel_idx].j.val),
        .b      (ent[sel_idx].k.val),
        .result (alu_result)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent[i] <= '0;
            end
            rs_rdy    <= 1'b0;
            rs_rob_id <= '0;
            rs_data   <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    ent[i].busy <= 1'b0;
                end
                rs_rdy <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (ent[i].busy) begin
                        ent[i].j <= wake_operand(ent[i].j, lsb_rdy, lsb_rob_id, lsb_data,
                                                 rs_bcast, rs_rob_id, rs_data);
                        ent[i].k <= wake_operand(ent[i].k, lsb_rdy, lsb_rob_id, lsb_data,
                                                 rs_bcast, rs_rob_id, rs_data);
                    end
                end
                if (sel_go) begin
                    ent[sel_idx].busy <= 1'b0;
                    rs_rdy            <= 1'b1;
                    rs_rob_id         <= ent[sel_idx].rob_id;
                    rs_data           <= alu_result;
                end else if (rs_en) begin
                    rs_rdy <= 1'b0;
                end
                // The slot freed by sel_go still reads busy here, so it is not reused this edge.
                if (iss_en && !full) begin
                    ent[free_idx] <= '{busy: 1'b1, op: iss_op, rob_id: iss_rob_id,
                                       j: iss_j, k: iss_k};
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - scoreboard bench for reservation_station
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int RS_SIZE  = 8;
    localparam int RS_WIDTH = 3;

    logic                 clk_in = 1'b0;
    logic                 rst_in, rdy_in, iss_en, iss_qj_busy, iss_qk_busy;
    logic [3:0]           iss_op;
    logic [ROB_WIDTH-1:0] iss_rob_id, iss_qj, iss_qk, lsb_rob_id, rs_rob_id;
    logic [31:0]          iss_vj, iss_vk, lsb_data, rs_data;
    logic                 full, lsb_rdy, rs_rdy, rs_en, flush;

    typedef struct packed {
        logic [ROB_WIDTH-1:0] rob;
        logic [31:0]          data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    reservation_station #(.RS_SIZE(RS_SIZE), .RS_WIDTH(RS_WIDTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .iss_en(iss_en),
        .iss_op(iss_op), .iss_rob_id(iss_rob_id), .iss_vj(iss_vj), .iss_vk(iss_vk),
        .iss_qj_busy(iss_qj_busy), .iss_qk_busy(iss_qk_busy), .iss_qj(iss_qj), .iss_qk(iss_qk),
        .full(full), .lsb_rdy(lsb_rdy), .lsb_rob_id(lsb_rob_id), .lsb_data(lsb_data),
        .rs_rdy(rs_rdy), .rs_rob_id(rs_rob_id), .rs_data(rs_data), .rs_en(rs_en), .flush(flush)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a + ~b + 32'd1;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << s;
            ALU_SRL:  return a >> s;
            ALU_SRA:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            ALU_SLT:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [ROB_WIDTH-1:0] rob,
                         input logic [31:0] vj, input logic [31:0] vk,
                         input logic qjb, input logic [ROB_WIDTH-1:0] qj,
                         input logic qkb, input logic [ROB_WIDTH-1:0] qk);
        iss_op = op; iss_rob_id = rob; iss_vj = vj; iss_vk = vk;
        iss_qj_busy = qjb; iss_qj = qj; iss_qk_busy = qkb; iss_qk = qk;
        iss_en = 1'b1;
        tick;
        iss_en = 1'b0;
    endtask

    task automatic wait_rdy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rs_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        rst_in = 1'b1; rdy_in = 1'b1; iss_en = 1'b0; rs_en = 1'b1; flush = 1'b0;
        lsb_rdy = 1'b0; lsb_rob_id = '0; lsb_data = '0;
        iss_op = '0; iss_rob_id = '0; iss_vj = '0; iss_vk = '0;
        iss_qj_busy = 1'b0; iss_qk_busy = 1'b0; iss_qj = '0; iss_qk = '0;
        tick; tick;
        checks++;
        if (rs_rdy !== 1'b0 || rs_rob_id !== '0 || rs_data !== '0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b rob=%0h data=%0h full=%b, expected all zero",
                     rs_rdy, rs_rob_id, rs_data, full);
        end
        rst_in = 1'b0;
        tick;
    endtask

    task automatic test_add;
        exp_t e;
        sb.push_back('{rob: 4'd5, data: 32'd12});
        issue(ALU_ADD, 4'd5, 32'd5, 32'd7, 1'b0, '0, 1'b0, '0);
        checks++;
        if (rs_rdy !== 1'b0) begin
            errors++; $display("FAIL add_early: rs_rdy=%b after issue edge, expected 0", rs_rdy);
        end
        tick;
        checks++;
        if (rs_rdy !== 1'b1) begin
            errors++; $display("FAIL add_latency: rs_rdy=%b on cycle 2, expected 1", rs_rdy);
        end else begin
            e = sb.pop_front();
            checks++;
            if (rs_rob_id !== e.rob || rs_data !== e.data) begin
                errors++; $display("FAIL add_result: rob=%0h data=%0h, expected rob=%0h data=%0h",
                                   rs_rob_id, rs_data, e.rob, e.data);
            end
        end
        tick;
    endtask

    task automatic test_wakeup;
        exp_t e;
        bit   ok;
        sb.push_back('{rob: 4'd6, data: 32'd6});
        issue(ALU_SUB, 4'd6, 32'hDEAD, 32'd4, 1'b1, 4'd3, 1'b0, '0);
        tick;
        checks++;
        if (rs_rdy !== 1'b0) begin
            errors++; $display("FAIL wake_pending: rs_rdy=%b with operand pending, expected 0", rs_rdy);
        end
        lsb_rdy = 1'b1; lsb_rob_id = 4'd3; lsb_data = 32'd10;
        tick;
        lsb_rdy = 1'b0;
        checks++;
        if (rs_rdy !== 1'b0) begin
            errors++; $display("FAIL wake_select_early: rs_rdy=%b on wake edge, expected 0", rs_rdy);
        end
        tick;
        e = sb.pop_front();
        checks++;
        if (rs_rdy !== 1'b1 || rs_rob_id !== e.rob || rs_data !== e.data) begin
            errors++; $display("FAIL wake_lsb: rdy=%b rob=%0h data=%0h, expected 1 %0h %0h",
                               rs_rdy, rs_rob_id, rs_data, e.rob, e.data);
        end
        tick;
        // operand resolved by a broadcast in the very cycle it issues
        sb.push_back('{rob: 4'd7, data: 32'd15});
        lsb_rdy = 1'b1; lsb_rob_id = 4'd3; lsb_data = 32'd20;
        issue(ALU_SUB, 4'd7, 32'h0, 32'd5, 1'b1, 4'd3, 1'b0, '0);
        lsb_rdy = 1'b0;
        tick;
        e = sb.pop_front();
        checks++;
        if (rs_rdy !== 1'b1 || rs_rob_id !== e.rob || rs_data !== e.data) begin
            errors++; $display("FAIL issue_capture: rdy=%b rob=%0h data=%0h, expected 1 %0h %0h",
                               rs_rdy, rs_rob_id, rs_data, e.rob, e.data);
        end
        tick;
        // dependent woken by the station's own accepted result
        sb.push_back('{rob: 4'd8, data: 32'd3});
        sb.push_back('{rob: 4'd9, data: 32'd13});
        issue(ALU_ADD, 4'd8, 32'd1, 32'd2, 1'b0, '0, 1'b0, '0);
        issue(ALU_ADD, 4'd9, 32'h0, 32'd10, 1'b1, 4'd8, 1'b0, '0);
        for (int n = 0; n < 2; n++) begin
            wait_rdy(ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL self_bcast_timeout: rs_rdy=0, expected result %0d", n);
            end else begin
                e = sb.pop_front();
                if (rs_rob_id !== e.rob || rs_data !== e.data) begin
                    errors++; $display("FAIL self_bcast: rob=%0h data=%0h, expected rob=%0h data=%0h",
                                       rs_rob_id, rs_data, e.rob, e.data);
                end
                tick;
            end
        end
    endtask

    task automatic test_full;
        for (int i = 0; i < RS_SIZE; i++) begin
            issue(ALU_ADD, ROB_WIDTH'(i), 32'h0, 32'(i), 1'b1, ROB_WIDTH'(8 + i), 1'b0, '0);
        end
        checks++;
        if (full !== 1'b1) begin
            errors++; $display("FAIL full_set: full=%b after 8 issues, expected 1", full);
        end
        issue(ALU_ADD, 4'd15, 32'd1, 32'd1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rs_rdy !== 1'b0 || full !== 1'b1) begin
                errors++; $display("FAIL full_ignore: rdy=%b full=%b, expected 0 1", rs_rdy, full);
            end
            tick;
        end
        lsb_rdy = 1'b1; lsb_rob_id = 4'd10; lsb_data = 32'd100;
        tick;
        lsb_rdy = 1'b0;
        checks++;
        if (full !== 1'b1) begin
            errors++; $display("FAIL full_hold: full=%b before result, expected 1", full);
        end
        tick;
        checks++;
        if (full !== 1'b0 || rs_rdy !== 1'b1 || rs_rob_id !== 4'd2 || rs_data !== 32'd102) begin
            errors++; $display("FAIL full_release: full=%b rdy=%b rob=%0h data=%0h, expected 0 1 2 66",
                               full, rs_rdy, rs_rob_id, rs_data);
        end
        flush = 1'b1;
        tick;
        flush = 1'b0;
    endtask

    task automatic test_backpressure;
        bit ok;
        rs_en = 1'b0;
        issue(ALU_XOR, 4'd1, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, '0, 1'b0, '0);
        issue(ALU_OR, 4'd2, 32'd1, 32'd2, 1'b0, '0, 1'b0, '0);
        wait_rdy(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL bp_timeout: rs_rdy=0, expected 1");
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rs_rdy !== 1'b1 || rs_rob_id !== 4'd1 || rs_data !== 32'h0000_FF00) begin
                errors++; $display("FAIL bp_hold: rdy=%b rob=%0h data=%0h, expected 1 1 ff00",
                                   rs_rdy, rs_rob_id, rs_data);
            end
            tick;
        end
        rs_en = 1'b1;
        tick;
        checks++;
        if (rs_rdy !== 1'b1 || rs_rob_id !== 4'd2 || rs_data !== 32'd3) begin
            errors++; $display("FAIL bp_second: rdy=%b rob=%0h data=%0h, expected 1 2 3",
                               rs_rdy, rs_rob_id, rs_data);
        end
        tick;
        checks++;
        if (rs_rdy !== 1'b0) begin
            errors++; $display("FAIL bp_drain: rs_rdy=%b, expected 0", rs_rdy);
        end
    endtask

    task automatic test_back_to_back;
        localparam int N = 12;
        int first_cyc, last_cyc;
        first_cyc = 0; last_cyc = 0;
        fork
            begin
                logic [31:0] a, b;
                sb.push_back('{rob: 4'd0, data: 32'hC000_0000});
                issue(ALU_SRA, 4'd0, 32'h8000_0000, 32'h0000_0021, 1'b0, '0, 1'b0, '0);
                sb.push_back('{rob: 4'd1, data: 32'd1});
                issue(ALU_SLTU, 4'd1, 32'd1, 32'hFFFF_FFFF, 1'b0, '0, 1'b0, '0);
                for (int k = 0; k < 10; k++) begin
                    a = $urandom; b = $urandom;
                    sb.push_back('{rob: ROB_WIDTH'(k + 2), data: model(4'(k), a, b)});
                    issue(4'(k), ROB_WIDTH'(k + 2), a, b, 1'b0, '0, 1'b0, '0);
                end
            end
            begin
                exp_t e;
                bit   ok;
                for (int n = 0; n < N; n++) begin
                    wait_rdy(ok);
                    checks++;
                    if (!ok) begin
                        errors++; $display("FAIL b2b_timeout: result %0d never arrived", n);
                        break;
                    end
                    if (n == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    e = sb.pop_front();
                    if (rs_rob_id !== e.rob || rs_data !== e.data) begin
                        errors++; $display("FAIL b2b_result%0d: rob=%0h data=%0h, expected rob=%0h data=%0h",
                                           n, rs_rob_id, rs_data, e.rob, e.data);
                    end
                    tick;
                end
            end
        join
        checks++;
        if (last_cyc - first_cyc != N - 1) begin
            errors++; $display("FAIL b2b_rate: %0d cycles for %0d results, expected %0d",
                               last_cyc - first_cyc, N, N - 1);
        end
    endtask

    task automatic test_flush;
        bit ok;
        rs_en = 1'b0;
        issue(ALU_ADD, 4'd1, 32'd1, 32'd1, 1'b0, '0, 1'b0, '0);
        issue(ALU_ADD, 4'd2, 32'd2, 32'd2, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            issue(ALU_ADD, ROB_WIDTH'(3 + i), 32'd0, 32'd0, 1'b1, ROB_WIDTH'(12 + i), 1'b0, '0);
        end
        wait_rdy(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL flush_setup: rs_rdy=0 before flush, expected 1");
        end
        flush = 1'b1;
        issue(ALU_ADD, 4'd10, 32'd4, 32'd4, 1'b0, '0, 1'b0, '0);
        flush = 1'b0;
        checks++;
        if (rs_rdy !== 1'b0 || full !== 1'b0) begin
            errors++; $display("FAIL flush_clear: rdy=%b full=%b, expected 0 0", rs_rdy, full);
        end
        rs_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            lsb_rdy = (i < 3); lsb_rob_id = ROB_WIDTH'(12 + i); lsb_data = 32'd9;
            tick;
            checks++;
            if (rs_rdy !== 1'b0) begin
                errors++; $display("FAIL flush_stale: rs_rdy=%b rob=%0h, expected 0", rs_rdy, rs_rob_id);
            end
        end
        lsb_rdy = 1'b0;
    endtask

    task automatic test_stall;
        issue(ALU_ADD, 4'd9, 32'd3, 32'd4, 1'b0, '0, 1'b0, '0);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (rs_rdy !== 1'b0) begin
                errors++; $display("FAIL stall_hold_idle: rs_rdy=%b while frozen, expected 0", rs_rdy);
            end
        end
        rdy_in = 1'b1;
        tick;
        checks++;
        if (rs_rdy !== 1'b1 || rs_rob_id !== 4'd9 || rs_data !== 32'd7) begin
            errors++; $display("FAIL stall_resume: rdy=%b rob=%0h data=%0h, expected 1 9 7",
                               rs_rdy, rs_rob_id, rs_data);
        end
        rdy_in = 1'b0;
        tick; tick;
        checks++;
        if (rs_rdy !== 1'b1 || rs_data !== 32'd7) begin
            errors++; $display("FAIL stall_hold_out: rdy=%b data=%0h, expected 1 7", rs_rdy, rs_data);
        end
        rdy_in = 1'b1;
        tick;
        checks++;
        if (rs_rdy !== 1'b0) begin
            errors++; $display("FAIL stall_accept: rs_rdy=%b, expected 0", rs_rdy);
        end
    endtask

    task automatic test_reset_midop;
        issue(ALU_ADD, 4'd3, 32'd1, 32'd1, 1'b0, '0, 1'b0, '0);
        rst_in = 1'b1;
        #1;
        checks++;
        if (rs_rdy !== 1'b0 || rs_rob_id !== '0 || rs_data !== '0 || full !== 1'b0) begin
            errors++; $display("FAIL reset_async: rdy=%b rob=%0h data=%0h full=%b, expected all zero",
                               rs_rdy, rs_rob_id, rs_data, full);
        end
        tick;
        rst_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (rs_rdy !== 1'b0) begin
                errors++; $display("FAIL reset_discard: rs_rdy=%b after reset, expected 0", rs_rdy);
            end
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_wakeup;
        test_full;
        test_backpressure;
        test_back_to_back;
        test_flush;
        test_stall;
        test_reset_midop;
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_empty: %0d results outstanding, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of entries (power of two).
REQ-002 SHALL have parameter RS_WIDTH, default 3, log2(RS_SIZE).
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port rdy_in, input, 1 bit: global enable; when low, all state holds.
REQ-006 SHALL have port iss_en, input, 1 bit: issue request from decoder.
REQ-007 SHALL have port iss_op, input, 4 bits: ALU opcode (ALU_* from package).
REQ-008 SHALL have port iss_rob_id, input, ROB_WIDTH bits: destination tag.
REQ-009 SHALL have ports iss_vj and iss_vk, input, 32 bits each: operand values.
REQ-010 SHALL have ports iss_qj_busy and iss_qk_busy, input, 1 bit each: operand still pending.
REQ-011 SHALL have ports iss_qj and iss_qk, input, ROB_WIDTH bits each: pending operand tags.
REQ-012 SHALL have port full, output, 1 bit: no free entry.
REQ-013 SHALL have ports lsb_rdy (1), lsb_rob_id (ROB_WIDTH), lsb_data (32), input: load-result broadcast.
REQ-014 SHALL have ports rs_rdy (1), rs_rob_id (ROB_WIDTH), rs_data (32), output: ALU result to reorder buffer, also self-broadcast.
REQ-015 SHALL have port rs_en, input, 1 bit: reorder buffer accepts rs_* this cycle.
REQ-016 SHALL have port flush, input, 1 bit: misprediction flush.

Function
REQ-017 SHALL assert full combinationally when all RS_SIZE entries are busy; iss_en while full is ignored.
REQ-018 SHALL allocate an issued instruction into the lowest-index free entry at the clock edge.
REQ-019 SHALL, on issue, capture an operand as ready if its q-tag matches a same-cycle valid broadcast (lsb or accepted rs), taking that data.
REQ-020 SHALL, each cycle, wake every busy entry operand whose tag matches a valid broadcast, storing the data and clearing pending.
REQ-021 SHALL treat an rs broadcast as valid only when rs_rdy and rs_en are both high.
REQ-022 SHALL select the lowest-index entry with both operands ready when the output register is empty or being accepted this cycle.
REQ-023 SHALL compute ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU on vj,vk; shifts use vk[4:0]; SLT/SLTU yield 0 or 1; arithmetic mod 2^32.
REQ-024 SHALL register the result: rs_rdy rises one cycle after selection, and the entry is freed at that edge.
REQ-025 SHALL hold rs_rdy, rs_rob_id, rs_data stable until rs_en is sampled high.
REQ-026 SHALL support simultaneous accept and new selection (back-to-back, one result per cycle).
REQ-027 SHALL allow an entry freed in a cycle to be reallocated only from the next cycle.
REQ-028 SHALL, on flush, clear all entries and rs_rdy at that edge, ignoring same-cycle iss_en.
REQ-029 SHALL freeze all state, including wakeups, when rdy_in is low; outputs hold.

Reset
REQ-030 SHALL, on rst_in high, immediately clear all busy bits, rs_rdy=0, rs_rob_id=0, rs_data=0; full=0.
REQ-031 SHALL discard in-flight selection when reset asserts mid-operation.

Structure
REQ-032 SHALL take ROB_WIDTH and ALU_* opcode constants from the shared definitions package.
REQ-033 SHALL place the combinational ALU in one sub-module named alu.

Verification
REQ-034 Issue ADD vj=5,vk=7 both ready -> rs_rdy cycle 2, rs_data=12, rs_rob_id=issued tag.
REQ-035 Issue SUB qj=3 pending, then lsb_rdy tag 3 data=10 with vk=4 -> rs_data=6 one cycle after wake-selection.
REQ-036 Fill 8 entries with pending operands -> full=1; 9th iss_en ignored; broadcast frees one -> full=0 after output.
REQ-037 Hold rs_en=0 for 3 cycles with 2 ready entries -> rs_* stable; rs_en=1 -> second result next cycle.
REQ-038 SRA vj=0x80000000,vk=0x21 -> rs_data=0xC0000000 (shift 1); SLTU 1<0xFFFFFFFF -> 1.
REQ-039 Flush with 4 busy entries and rs_rdy=1 -> next cycle rs_rdy=0, full=0, no stale result ever emitted.
